mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit for the execute stage, the successor to the behavioural MDU. Multiplies with shift-add, MUL_BITS bits per cycle, and divides with a restoring algorithm, one quotient bit per cycle; both are synthesisable, with no `*`, `/` or `%` operators. It owns the HI/LO registers and presents the same busy/stall contract to the pipeline controller. It adds two things the old unit lacked: a flush input (`cancel`) and a completion pulse (`done`).

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥ 8.
- MUL_BITS, 4, multiplier bits retired per cycle; must be 1, 2 or 4 and divide WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation request qualifier from pipeline controller.
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; other codes are treated as NONE.
- srca  input  WIDTH  rs operand.
- srcb  input  WIDTH  rt operand.
- cancel  input  1  flush; aborts the in-flight operation and blocks a same-cycle start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  unit occupied, or a start is being requested this cycle.
- done  output  1  one-cycle pulse marking the first cycle in which new HI/LO values are visible.

## Operation
- Start condition: `start = en & ~cancel & ~reset & state==IDLE & op∈{1..8} & ~(op∈{3,4} & srcb==0)`.
- Divide by zero (op 3 or 4 with srcb==0): silently ignored; no busy, no done, HI/LO unchanged.
- MTHI/MTLO: when `en & ~cancel & state==IDLE`, `hi` (or `lo`) ← srca at the edge. No busy, no done.
- States:
  - IDLE
  - MUL: counter loads WIDTH/MUL_BITS.
  - DIV: counter loads WIDTH.
  - FIX: sign correction, accumulate, HI/LO write.
- Transitions:
  - IDLE→MUL or IDLE→DIV on start.
  - MUL/DIV: counter decrements each cycle; at counter==1 the next state is FIX.
  - FIX→IDLE unconditionally.
  - Any state→IDLE on cancel or reset.
- At start, operands are latched. Signed ops (MULT, DIV, MADD, MSUB) latch magnitudes plus sign flags. |−2^(WIDTH−1)| is treated as the unsigned value 2^(WIDTH−1).
- MUL: 2·WIDTH-bit product accumulator; each cycle adds `mcand·mplier[MUL_BITS−1:0]` shifted into place, then shifts the multiplier right by MUL_BITS.
- DIV: restoring divider; each cycle shifts in one dividend bit, trial-subtracts, and sets the quotient bit if the result is non-negative.
- FIX:
  - Product is negated if sa^sb. Quotient is negated if sa^sb; remainder is negated if sa.
  - MULT/MULTU: {hi,lo} ← product.
  - DIV/DIVU: hi ← remainder, lo ← quotient.
  - MADD/MADDU: {hi,lo} ← {hi,lo} + product. MSUB/MSUBU: {hi,lo} ← {hi,lo} − product.
  - All arithmetic is modulo 2^(2·WIDTH); signed INT_MIN/−1 yields lo=INT_MIN, hi=0.
- Outputs:
  - `busy = start | (state != IDLE)`. `busy` is combinational on inputs in the start cycle only.
  - `done` is registered and high exactly one cycle after the FIX edge.
- cancel:
  - While in MUL/DIV/FIX, the next edge returns to IDLE with hi/lo unchanged and no done.
  - cancel has priority over the FIX write.
- reset: hi=0, lo=0, state=IDLE, done=0, busy=0, counters and latches cleared. This holds even if reset arrives mid-operation.

## Timing
- Start accepted in cycle 0.
- Multiply family: new hi/lo visible and done high in cycle N+2, with N = WIDTH/MUL_BITS. busy is high in cycles 0..N+1. WIDTH=32, MUL_BITS=4 gives results in cycle 10.
- Divide: results in cycle WIDTH+2 (34 at WIDTH=32). busy is high in cycles 0..WIDTH+1.
- MTHI/MTLO: value visible in cycle 1.
- A new start may be accepted in the cycle done is high; that cycle is IDLE.
- en/op/srca/srcb need only be valid in the start cycle; later changes are ignored.
- While busy, the controller stalls MFHI/MFLO and any further MDU op. The unit itself ignores all non-cancel inputs while state≠IDLE.

## Test plan
- MULT 0xFFFFFFFF×0x00000002, followed by MULTU with the same operands: MULT gives hi=0xFFFFFFFF, lo=0xFFFFFFFE in cycle 10 with done pulsed once; MULTU gives hi=0x00000001, lo=0xFFFFFFFE; busy is high in cycles 0–9 for each.
- DIV −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF in cycle 34. DIVU 7/2: lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- MTLO 5, then MADD 3×4: lo=17, hi=0. Then MSUBU 1×1 starting from hi=lo=0: hi=lo=0xFFFFFFFF.
- DIV x/0 with en: busy stays low, done stays 0, hi/lo unchanged. An immediately following MTHI 0x1234 gives hi=0x1234 in cycle 1.
- DIVU started, cancel in cycle 20: state IDLE by cycle 21, hi/lo hold their prior values, no done. cancel together with a start request: busy=0, nothing starts.
- reset asserted in cycle 5 of a MULT: hi=lo=0, busy=0, done=0 in the next cycle. Sweep over random operands at WIDTH=16 with MUL_BITS=1/2/4 must match a golden model.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier and restoring divider owning HI/LO
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int N_MUL = WIDTH / MUL_BITS;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_op;
  logic               r_sa;
  logic               r_sb;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_idle_req;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed_op;
  logic               w_start;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_partial;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_sub;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_hilo;

  assign w_idle_req  = en & ~cancel & (r_state == S_IDLE);
  assign w_is_mul    = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign w_is_div    = op inside {OP_DIV, OP_DIVU};
  assign w_signed_op = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  assign w_start     = w_idle_req & ~reset & (w_is_mul | (w_is_div & (srcb != '0)));

  // Magnitudes are unsigned, so |INT_MIN| naturally becomes 2^(WIDTH-1).
  assign w_sa    = w_signed_op & srca[WIDTH-1];
  assign w_sb    = w_signed_op & srcb[WIDTH-1];
  assign w_abs_a = w_sa ? -srca : srca;
  assign w_abs_b = w_sb ? -srcb : srcb;

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_qbit   = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dvsr;

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_dvd : r_dvd;
  assign w_rem  = r_sa ? -r_rem : r_rem;
  assign w_hilo = {r_hi, r_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_dvd    <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op     <= op;
            r_sa     <= w_sa;
            r_sb     <= w_sb;
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_dvd    <= w_abs_a;
            r_dvsr   <= w_abs_b;
            r_rem    <= '0;
            r_state  <= w_is_mul ? S_MUL : S_DIV;
            r_cnt    <= w_is_mul ? CW'(N_MUL) : CW'(WIDTH);
          end else if (w_idle_req && op == OP_MTHI) begin
            r_hi <= srca;
          end else if (w_idle_req && op == OP_MTLO) begin
            r_lo <= srca;
          end
        end
        S_MUL: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc    <= r_acc + w_partial;
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_DIV: begin
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_qbit ? w_sub : w_rem_sh[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (!cancel) begin
            r_done <= 1'b1;
            case (r_op)
              OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
              OP_DIV, OP_DIVU: begin
                r_hi <= w_rem;
                r_lo <= w_quo;
              end
              OP_MADD, OP_MADDU: {r_hi, r_lo} <= w_hilo + w_prod;
              OP_MSUB, OP_MSUBU: {r_hi, r_lo} <= w_hilo - w_prod;
              default: r_done <= 1'b0;
            endcase
          end
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = w_start | (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - randomized self-checking bench for mdu_iter against an arithmetic model
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  logic        rst16;
  logic        en16;
  logic [3:0]  op16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cancel16;
  logic [15:0] h16 [3];
  logic [15:0] l16 [3];
  logic [2:0]  busy16;
  logic [2:0]  done16;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] sh_hi [3];
  logic [31:0] sh_lo [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .MUL_BITS(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .srca(srca), .srcb(srcb),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  for (genvar k = 0; k < 3; k++) begin : g_w16
    mdu_iter #(.WIDTH(16), .MUL_BITS(1 << k)) u_dut16 (
      .clk(clk), .reset(rst16), .en(en16), .op(op16), .srca(a16), .srcb(b16),
      .cancel(cancel16), .hi(h16[k]), .lo(l16[k]), .busy(busy16[k]), .done(done16[k])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign-extended or zero-extended operands.
  function automatic void ref_model(input int w, input logic [3:0] o,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hi_in, input logic [31:0] lo_in,
                                    output logic [31:0] hi_out, output logic [31:0] lo_out);
    logic [63:0] mask, hilo, prod, ua, ub, res;
    logic [31:0] wmask;
    longint sa, sb, q, r;
    mask  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    wmask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    ua    = (w == 32) ? {32'b0, a} : {48'b0, a[15:0]};
    ub    = (w == 32) ? {32'b0, b} : {48'b0, b[15:0]};
    sa    = (w == 32) ? longint'($signed(a)) : longint'($signed(a[15:0]));
    sb    = (w == 32) ? longint'($signed(b)) : longint'($signed(b[15:0]));
    hilo  = (w == 32) ? {hi_in, lo_in} : {32'b0, hi_in[15:0], lo_in[15:0]};
    prod  = (o inside {4'd1, 4'd5, 4'd7}) ? 64'(sa * sb) : ua * ub;
    res   = hilo;
    hi_out = hi_in;
    lo_out = lo_in;
    case (o)
      4'd1, 4'd2: res = prod & mask;
      4'd5, 4'd6: res = (hilo + prod) & mask;
      4'd7, 4'd8: res = (hilo - prod) & mask;
      default: res = hilo;
    endcase
    if (w == 32) begin
      hi_out = res[63:32];
      lo_out = res[31:0];
    end else begin
      hi_out = {16'b0, res[31:16]};
      lo_out = {16'b0, res[15:0]};
    end
    if (o == 4'd3) begin
      q = sa / sb;
      r = sa % sb;
      hi_out = 32'(r) & wmask;
      lo_out = 32'(q) & wmask;
    end else if (o == 4'd4) begin
      hi_out = 32'(ua % ub) & wmask;
      lo_out = 32'(ua / ub) & wmask;
    end
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h1;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    int lat, done_at, ndone;
    bit busy_ok;
    lat = (o inside {4'd3, 4'd4}) ? 34 : 10;
    ref_model(32, o, a, b, m_hi, m_lo, eh, el);
    en = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    chk({tag, "_busy0"}, 64'(busy), 64'd1);
    @(posedge clk); #1;
    en = 1'b0; op = 4'($urandom); srca = $urandom; srcb = $urandom;
    done_at = -1; ndone = 0; busy_ok = 1'b1;
    for (int c = 1; c <= lat + 3; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (busy != (c < lat)) busy_ok = 1'b0;
    end
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(lat));
    chk({tag, "_done_count"}, 64'(ndone), 64'd1);
    chk({tag, "_busy_profile"}, 64'(busy_ok), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
  endtask

  task automatic mt32(input logic [3:0] o, input logic [31:0] v, input string tag);
    en = 1'b1; op = o; srca = v; srcb = $urandom;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    en = 1'b0; op = 4'd0;
    if (o == 4'd9) m_hi = v; else m_lo = v;
    @(negedge clk);
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    chk({tag, "_done"}, 64'(done), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] eh [3];
    logic [31:0] el [3];
    int lat [3];
    int done_at [3];
    int ndone [3];
    bit busy_ok [3];
    for (int k = 0; k < 3; k++) begin
      ref_model(16, o, {16'b0, a}, {16'b0, b}, sh_hi[k], sh_lo[k], eh[k], el[k]);
      lat[k] = (o inside {4'd3, 4'd4}) ? 18 : (16 >> k) + 2;
      done_at[k] = -1; ndone[k] = 0; busy_ok[k] = 1'b1;
    end
    en16 = 1'b1; op16 = o; a16 = a; b16 = b;
    @(negedge clk);
    chk("w16_busy0", 64'(busy16), 64'h7);
    @(posedge clk); #1;
    en16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (done16[k]) begin
          ndone[k]++;
          if (done_at[k] < 0) done_at[k] = c;
        end
        if (busy16[k] != (c < lat[k])) busy_ok[k] = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w16_mb%0d_op%0d_done_cycle", 1 << k, o), 64'(done_at[k]), 64'(lat[k]));
      chk($sformatf("w16_mb%0d_op%0d_done_count", 1 << k, o), 64'(ndone[k]), 64'd1);
      chk($sformatf("w16_mb%0d_op%0d_busy", 1 << k, o), 64'(busy_ok[k]), 64'd1);
      chk($sformatf("w16_mb%0d_op%0d_hi", 1 << k, o), {48'b0, h16[k]}, 64'(eh[k]));
      chk($sformatf("w16_mb%0d_op%0d_lo", 1 << k, o), {48'b0, l16[k]}, 64'(el[k]));
      sh_hi[k] = eh[k]; sh_lo[k] = el[k];
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    logic [15:0] qa, qb;
    bit          quiet;
    reset = 1'b1; en = 1'b0; op = 4'd0; srca = '0; srcb = '0; cancel = 1'b0;
    rst16 = 1'b1; en16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0; cancel16 = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int k = 0; k < 3; k++) begin
      sh_hi[k] = '0; sh_lo[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; rst16 = 1'b0;

    issue32(4'd1, 32'hFFFF_FFFF, 32'h2, "mult");
    chk("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_lo_const", 64'(lo), 64'hFFFF_FFFE);
    issue32(4'd2, 32'hFFFF_FFFF, 32'h2, "multu");
    chk("multu_hi_const", 64'(hi), 64'h1);
    chk("multu_lo_const", 64'(lo), 64'hFFFF_FFFE);
    issue32(4'd3, 32'hFFFF_FFF9, 32'h2, "div_neg7_2");
    chk("div_neg7_2_lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg7_2_hi_const", 64'(hi), 64'hFFFF_FFFF);
    issue32(4'd4, 32'h7, 32'h2, "divu_7_2");
    chk("divu_7_2_lo_const", 64'(lo), 64'h3);
    chk("divu_7_2_hi_const", 64'(hi), 64'h1);
    issue32(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_intmin");
    chk("div_intmin_lo_const", 64'(lo), 64'h8000_0000);
    chk("div_intmin_hi_const", 64'(hi), 64'h0);

    mt32(4'd10, 32'd5, "mtlo5");
    issue32(4'd5, 32'd3, 32'd4, "madd");
    chk("madd_lo_const", 64'(lo), 64'd17);
    chk("madd_hi_const", 64'(hi), 64'd0);
    mt32(4'd9, 32'd0, "mthi0");
    mt32(4'd10, 32'd0, "mtlo0");
    issue32(4'd8, 32'd1, 32'd1, "msubu");
    chk("msubu_hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("msubu_lo_const", 64'(lo), 64'hFFFF_FFFF);

    en = 1'b1; op = 4'd3; srca = 32'd123; srcb = 32'd0;
    @(negedge clk);
    chk("div0_busy", 64'(busy), 64'd0);
    chk("div0_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    mt32(4'd9, 32'h1234, "mthi_after_div0");
    chk("mthi_after_div0_const", 64'(hi), 64'h1234);

    en = 1'b1; op = 4'd4; srca = 32'd1000; srcb = 32'd7;
    @(negedge clk);
    chk("cancel_div_busy0", 64'(busy), 64'd1);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_div_busy_c20", 64'(busy), 64'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_div_busy_c21", 64'(busy), 64'd0);
    quiet = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("cancel_div_quiet", 64'(quiet), 64'd1);
    chk("cancel_div_hi", 64'(hi), 64'(m_hi));
    chk("cancel_div_lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;

    en = 1'b1; op = 4'd1; srca = 32'd3; srcb = 32'd5; cancel = 1'b1;
    @(negedge clk);
    chk("cancel_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    en = 1'b0; cancel = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk("cancel_start_quiet", 64'(quiet), 64'd1);
    chk("cancel_start_hi", 64'(hi), 64'(m_hi));
    chk("cancel_start_lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;

    mt32(4'd10, 32'hDEAD_BEEF, "mtlo_pre_reset");
    en = 1'b1; op = 4'd1; srca = 32'd5; srcb = 32'd7;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy_c5", 64'(busy), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      ro = 4'($urandom_range(1, 8));
      ra = pick32();
      rb = pick32();
      if (ro inside {4'd3, 4'd4} && rb == 0) rb = 32'd1;
      issue32(ro, ra, rb, $sformatf("rand32_%0d_op%0d", i, ro));
    end

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(1, 8));
      qa = pick16();
      qb = pick16();
      if (ro inside {4'd3, 4'd4} && qb == 0) qb = 16'd3;
      issue16(ro, qa, qb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
